pwm_capture: RTL

Measures an incoming PWM waveform (servo/ESC feedback, RC receiver channel, or loopback of our own motor PWM) and reports high time, period, and an 8-bit duty code on the same 0..255 scale the motor PWM generator consumes. It is the receive-side counterpart of the motor PWM path and sits between a board input pin and the control logic. Duty is computed by a multi-cycle restoring divider, with no combinational divide.

---
 rtl/pwm_capture.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and reports high time, period
// and an 8-bit duty code, floor(high*256/period), on the same 0..255 scale the
// motor PWM generator consumes.
//
// The duty code comes from an 8-step restoring divider that produces one
// quotient bit per cycle, so there is no combinational divide.
//
// Parameters
//   CNT_W     width of the high-time/period counters (max period 2^CNT_W-1)
//   TIMEOUT   cycles of run_cnt before the input is declared stuck (< 2^CNT_W)
//   FILT_LEN  consecutive stable samples the glitch filter needs (filter build only)
//
// Build option
//   PWM_CAPTURE_FILTER_EN  when defined, a glitch filter sits between the
//                          synchronizer and the edge detector. It adds FILT_LEN
//                          cycles of latency to both edges and rejects pulses
//                          shorter than FILT_LEN cycles.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset (async assert, sync release)
//   pwm_in      asynchronous PWM input pin
//   duty        floor(high*256/period) of the last complete cycle
//   high_cnt    high time of the last complete cycle, in clk cycles
//   period_cnt  rising-to-rising period of the last complete cycle
//   valid       one-cycle strobe when duty/high_cnt/period_cnt update
//   timeout     high while the input is stuck; cleared by the next normal result
//   overrun     sticky; a period completed while the divider was still busy
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no reference edge yet; waiting for a rising edge
// S_HIGH | input high; run_cnt counting, waiting for the falling edge
// S_LOW  | input low; run_cnt counting, waiting for the closing rising edge

module pwm_capture #(
    parameter int CNT_W    = 20,
    parameter int TIMEOUT  = 800000
`ifdef PWM_CAPTURE_FILTER_EN
    ,
    parameter int FILT_LEN = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [7:0]       duty,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronizer, optional filter, edge-detect register
    // ------------------------------------------------------------------
    logic sync_1, sync_2;
    logic lvl, lvl_q;
    logic rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] filt_cnt;
    logic            filt_lvl;

    // The filtered level follows sync_2 only after FILT_LEN consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b0;
        end else if (sync_2 == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
            filt_cnt <= '0;
            filt_lvl <= sync_2;
        end else begin
            filt_cnt <= filt_cnt + FC_W'(1);
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync_2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] h_q;
    logic             at_to;
    logic             cnt_one, cnt_clr, h_latch, div_load, to_go, to_report;

    assign at_to = (run_cnt >= TO_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_one  = 1'b0;
        cnt_clr  = 1'b0;
        h_latch  = 1'b0;
        div_load = 1'b0;
        to_go    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HIGH;
                    cnt_one = 1'b1;
                end else if (at_to && !timeout) begin
                    // Only the first stuck interval is reported from IDLE.
                    to_go   = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    state_d = S_LOW;
                    h_latch = 1'b1;
                end else if (at_to) begin
                    state_d = S_IDLE;
                    to_go   = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d  = S_HIGH;
                    div_load = 1'b1;
                    cnt_one  = 1'b1;
                end else if (at_to) begin
                    state_d = S_IDLE;
                    to_go   = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A stuck input that is already flagged goes back to IDLE silently.
    assign to_report = to_go & ~timeout;

    // The rising-edge cycle counts as 1, so a closing edge sees run_cnt = H+L.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            h_q     <= '0;
        end else begin
            if (cnt_one) begin
                run_cnt <= CNT_W'(1);
            end else if (cnt_clr) begin
                run_cnt <= '0;
            end else if (run_cnt != CNT_MAX) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            if (h_latch) begin
                h_q <= run_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Restoring divider: quotient = floor(h * 256 / p), MSB first.
    // h < p always holds, so the partial remainder stays below p and the
    // shifted value fits in CNT_W+1 bits.
    // ------------------------------------------------------------------
    logic [CNT_W:0]   rem_q, rem_sh, rem_nx;
    logic [CNT_W-1:0] div_p, div_h;
    logic [7:0]       quo_q, quo_nx;
    logic [3:0]       div_left;
    logic             div_busy, div_ge, div_done;

    always_comb begin
        rem_sh = rem_q << 1;
        div_ge = (rem_sh >= {1'b0, div_p});
        rem_nx = div_ge ? (rem_sh - {1'b0, div_p}) : rem_sh;
        quo_nx = {quo_q[6:0], div_ge};
    end

    // A new load or a timeout in the last iteration wins over completion.
    assign div_done = div_busy && (div_left == 4'd1) && !div_load && !to_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            div_p    <= '0;
            div_h    <= '0;
            quo_q    <= '0;
            div_left <= '0;
            div_busy <= 1'b0;
        end else if (div_load) begin
            rem_q    <= {1'b0, h_q};
            div_p    <= run_cnt;
            div_h    <= h_q;
            quo_q    <= '0;
            div_left <= 4'd8;
            div_busy <= 1'b1;
        end else if (to_go) begin
            div_busy <= 1'b0;
        end else if (div_busy) begin
            rem_q    <= rem_nx;
            quo_q    <= quo_nx;
            div_left <= div_left - 4'd1;
            if (div_left == 4'd1) begin
                div_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty       <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (div_load && div_busy) begin
                overrun <= 1'b1;
            end
            if (div_done) begin
                valid      <= 1'b1;
                duty       <= quo_nx;
                high_cnt   <= div_h;
                period_cnt <= div_p;
                timeout    <= 1'b0;
            end else if (to_report) begin
                valid      <= 1'b1;
                duty       <= {8{lvl}};
                high_cnt   <= '0;
                period_cnt <= '0;
                timeout    <= 1'b1;
            end
        end
    end

endmodule
